// File: rtl/mips_pkg.sv
// Shared register-file types and widths for the MIPS datapath.
package mips_pkg;
  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DEPTH  = 2**REG_ADDR_W;
  localparam int REG_CNT_W  = 8;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_CNT_W-1:0]  reg_cnt_t;
endpackage

// File: rtl/reg_file_wr_demux_if.sv
// Register-file port bundle: one write port, two combinational read ports, write counter.
interface reg_file_wr_demux_if
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  reg_cnt_t          wr_cnt;

  modport master (output we, wa, wd, ra1, ra2, input rd1, rd2, wr_cnt);
  modport slave  (input we, wa, wd, ra1, ra2, output rd1, rd2, wr_cnt);
endinterface

// File: rtl/reg_file_wr_demux_decoder.sv
// Write-address one-hot decoder gated by write enable; line 0 (r0) never fires.
module reg_wr_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    wa_i,
  output logic [2**ADDR_W-1:0] onehot_o
);
  // An unknown we fails the if-test, so no line is enabled.
  always_comb begin
    onehot_o = '0;
    if (we_i) onehot_o[wa_i] = 1'b1;
    onehot_o[0] = 1'b0;
  end
endmodule

// File: rtl/reg_file_wr_demux.sv
// 32x32 MIPS register file: one-hot write demux, two combinational read ports,
// saturating commit counter. Optional write-to-read forwarding under REG_FILE_BYPASS_EN.
module reg_file_wr_demux
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic                clk,
  input logic                rst_n,
  reg_file_wr_demux_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  wen;
  logic [DATA_W-1:0] regs_q [DEPTH];
  reg_cnt_t          cnt_q, cnt_d;
  logic              commit;

  reg_wr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .we_i     (bus.we),
    .wa_i     (bus.wa),
    .onehot_o (wen)
  );

  // Entry 0 is cleared by reset and never enabled, so it reads as 0 without a special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++)
        if (wen[i]) regs_q[i] <= bus.wd;
    end
  end

  assign commit = |wen;

  always_comb begin
    cnt_d = cnt_q;
    if (commit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Reads are forced to 0 during reset so a forwarded wd cannot leak out.
  always_comb begin
    bus.rd1 = '0;
    bus.rd2 = '0;
    if (rst_n) begin
`ifdef REG_FILE_BYPASS_EN
      bus.rd1 = wen[bus.ra1] ? bus.wd : regs_q[bus.ra1];
      bus.rd2 = wen[bus.ra2] ? bus.wd : regs_q[bus.ra2];
`else
      bus.rd1 = regs_q[bus.ra1];
      bus.rd2 = regs_q[bus.ra2];
`endif
    end
  end

  assign bus.wr_cnt = cnt_q;

  always @(posedge clk) begin
    if (rst_n) we_known: assert (!$isunknown(bus.we));
  end
endmodule

// File: tb/tb_reg_file_wr_demux.sv
// Directed bench for reg_file_wr_demux with a reference model and an expectation queue.
module tb_reg_file_wr_demux;
  import mips_pkg::*;

  typedef struct {
    string       tag;
    int          sel;   // 0: rd1, 1: rd2, 2: wr_cnt
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  logic [31:0] mdl [32];
  int          mcnt;

  reg_file_wr_demux_if bus ();

  reg_file_wr_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.sel)
        0:       obs = bus.rd1;
        1:       obs = bus.rd2;
        default: obs = {24'd0, bus.wr_cnt};
      endcase
      tests++;
      assert (obs === x.exp) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Advance one rising edge, updating the model from the inputs applied across it.
  task automatic tick();
    @(posedge clk);
    if (rst_n && bus.we === 1'b1 && bus.wa != 5'd0) begin
      mdl[bus.wa] = bus.wd;
      if (mcnt < 255) mcnt++;
    end
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcnt = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.wa = a; bus.wd = d;
    tick();
    bus.we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.ra1 = '0; bus.ra2 = '0;
    model_reset();

    // 1: reset held for two edges with random write traffic
    for (int c = 0; c < 2; c++) begin
      bus.we = 1'($urandom); bus.wa = 5'($urandom); bus.wd = $urandom;
      @(posedge clk); #1;
    end
    for (int a = 0; a < 32; a++) begin
      bus.ra1 = 5'(a); bus.ra2 = 5'(31 - a); #1;
      push("rst_rd1", 0, 32'd0);
      push("rst_rd2", 1, 32'd0);
      drain();
    end
    push("rst_cnt", 2, 32'd0);
    drain();
    bus.we = 1'b0;
    rst_n = 1'b1;
    tick();

    // 2: basic write
    wr(5'd5, 32'hDEADBEEF);
    bus.ra1 = 5'd5; #1;
    push("wr5_rd1", 0, 32'hDEADBEEF);
    push("wr5_cnt", 2, 32'd1);
    drain();

    // 3: write to r0 discarded and not counted
    wr(5'd0, 32'hFFFFFFFF);
    bus.ra1 = 5'd0; bus.ra2 = 5'd0; #1;
    push("r0_rd1", 0, 32'd0);
    push("r0_rd2", 1, 32'd0);
    push("r0_cnt", 2, 32'd1);
    drain();

    // 4: same-cycle write/read of r7
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h1234; bus.ra2 = 5'd7; #1;
`ifdef REG_FILE_BYPASS_EN
    push("byp_pre_rd2", 1, 32'h1234);
`else
    push("byp_pre_rd2", 1, 32'd0);
`endif
    drain();
    tick();
    bus.we = 1'b0; #1;
    push("byp_post_rd2", 1, 32'h1234);
    push("byp_cnt", 2, 32'd2);
    drain();

    // 5: back-to-back writes, last edge wins; then saturation
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'd1;
    tick();
    bus.wd = 32'd2;
    tick();
    bus.we = 1'b0;
    bus.ra1 = 5'd3; bus.ra2 = 5'd3; #1;
    push("b2b_rd1", 0, 32'd2);
    push("b2b_rd2", 1, 32'd2);
    push("b2b_cnt", 2, 32'd4);
    drain();
    for (int i = 0; i < 300; i++) begin
      wr(5'(1 + (i % 31)), $urandom);
      if (i == 250) begin
        push("sat_cnt_mid", 2, mcnt);
        drain();
      end
    end
    for (int a = 0; a < 32; a += 5) begin
      bus.ra1 = 5'(a); bus.ra2 = 5'(a + 1); #1;
      push("bulk_rd1", 0, mdl[a]);
      push("bulk_rd2", 1, mdl[a + 1]);
      drain();
    end
    push("sat_cnt", 2, 32'd255);
    drain();

    // 6: reset pulse over an edge with a pending write to r9
    wr(5'd9, 32'hA5A5A5A5);
    bus.ra1 = 5'd9; #1;
    push("r9_rd1", 0, 32'hA5A5A5A5);
    drain();
    bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h5A5A5A5A;
    @(negedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    push("rstp_rd1", 0, 32'd0);
    push("rstp_cnt", 2, 32'd0);
    drain();
    tick();
    bus.we = 1'b0;
    rst_n = 1'b1;
    #1;
    push("rstp_lost_rd1", 0, 32'd0);
    push("rstp_lost_cnt", 2, 32'd0);
    drain();
    tick();
    push("rstp_after_rd1", 0, mdl[9]);
    push("rstp_after_cnt", 2, mcnt);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
